// File: rtl/full_adder_4bit_if.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_4bit_if
// Description : Operand/result bus for the registered ripple-carry adder.
//               The master drives operands and observes results; the slave
//               (the adder) drives results.
// Revision    : 1.0 - initial release
// ============================================================================
interface full_adder_4bit_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             overflow;
  logic             zero;
  logic             out_valid;

  modport master (
    output in_valid, A, B, Cin,
    input  S, Cout, overflow, zero, out_valid
  );

  modport slave (
    input  in_valid, A, B, Cin,
    output S, Cout, overflow, zero, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/full_adder_4bit.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_4bit
// Description : WIDTH-bit ripple-carry adder built from 1-bit full-adder
//               cells, with registered sum, carry-out, signed overflow and
//               zero flags. One result per valid cycle, latency 1.
//               Asynchronous active-low reset with synchronized release.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_4bit #(
  parameter int WIDTH = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  full_adder_4bit_if.slave  bus
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_overflow;
  logic             w_zero;
  logic             w_run;
  logic [1:0]       r_rst_sync;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_overflow;
  logic             r_zero;
  logic             r_out_valid;

  assign w_carry[0] = bus.Cin;

  // One full-adder cell per bit; carry ripples from bit 0 upward.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign w_sum[i]       = bus.A[i] ^ bus.B[i] ^ w_carry[i];
      assign w_carry[i + 1] = (bus.A[i] & bus.B[i]) |
                              (w_carry[i] & (bus.A[i] ^ bus.B[i]));
    end
  endgenerate

  // Signed overflow: carry into the MSB cell disagrees with carry out of it.
  assign w_overflow = w_carry[WIDTH] ^ w_carry[WIDTH-1];
  // Zero looks only at the sum bits; the carry-out is deliberately ignored.
  assign w_zero     = ~|w_sum;
  // Captures are allowed only once the release has crossed both sync stages.
  assign w_run      = r_rst_sync[1];

  // Reset synchronizer: assert immediately, release after two clk edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  // Result registers: load on valid, otherwise hold data and drop out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s         <= '0;
      r_cout      <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_run && bus.in_valid) begin
      r_s         <= w_sum;
      r_cout      <= w_carry[WIDTH];
      r_overflow  <= w_overflow;
      r_zero      <= w_zero;
      r_out_valid <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.S         = r_s;
  assign bus.Cout      = r_cout;
  assign bus.overflow  = r_overflow;
  assign bus.zero      = r_zero;
  assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_full_adder_4bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_full_adder_4bit
// Description : Directed self-checking bench for full_adder_4bit (WIDTH=4).
//               Observed result vector is {out_valid,Cout,overflow,zero,S}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_full_adder_4bit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  full_adder_4bit_if #(.WIDTH(4)) bus ();

  full_adder_4bit #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack observed outputs as {out_valid, Cout, overflow, zero, S}.
  function automatic logic [7:0] obs();
    return {bus.out_valid, bus.Cout, bus.overflow, bus.zero, bus.S};
  endfunction

  // Present operands on the falling edge, then settle just past the next rising edge.
  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
    @(negedge clk);
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.A        = 4'b0011;
    bus.B        = 4'b0001;
    bus.Cin      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 8'b0000_0000) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", obs(), 8'b0000_0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== 8'b0000_0000) begin
      errors++;
      $display("FAIL reset_release_edge1: got %b expected %b", obs(), 8'b0000_0000);
    end
    repeat (3) drive(1'b0, 4'b0000, 4'b0000, 1'b0);
  endtask

  task automatic test_basic();
    drive(1'b1, 4'b0000, 4'b0001, 1'b0);
    checks++;
    if (obs() !== 8'b1000_0001) begin
      errors++;
      $display("FAIL basic_0p1: got %b expected %b", obs(), 8'b1000_0001);
    end
  endtask

  task automatic test_carry();
    drive(1'b1, 4'b1111, 4'b1101, 1'b0);
    checks++;
    if (obs() !== 8'b1100_1100) begin
      errors++;
      $display("FAIL carry_f_d: got %b expected %b", obs(), 8'b1100_1100);
    end
    drive(1'b1, 4'b1101, 4'b1111, 1'b1);
    checks++;
    if (obs() !== 8'b1100_1101) begin
      errors++;
      $display("FAIL carry_d_f_cin: got %b expected %b", obs(), 8'b1100_1101);
    end
  endtask

  task automatic test_overflow_zero();
    drive(1'b1, 4'b0101, 4'b0110, 1'b0);
    checks++;
    if (obs() !== 8'b1010_1011) begin
      errors++;
      $display("FAIL ovf_5_6: got %b expected %b", obs(), 8'b1010_1011);
    end
    drive(1'b1, 4'b0111, 4'b1000, 1'b1);
    checks++;
    if (obs() !== 8'b1101_0000) begin
      errors++;
      $display("FAIL zero_7_8_cin: got %b expected %b", obs(), 8'b1101_0000);
    end
    drive(1'b1, 4'b1111, 4'b0001, 1'b0);
    checks++;
    if (obs() !== 8'b1101_0000) begin
      errors++;
      $display("FAIL zero_ignores_cout: got %b expected %b", obs(), 8'b1101_0000);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 4'b0000, 4'b0000, 1'b1);
    checks++;
    if (obs() !== 8'b1000_0001) begin
      errors++;
      $display("FAIL cin_only: got %b expected %b", obs(), 8'b1000_0001);
    end
    drive(1'b0, 4'b1111, 4'b0000, 1'b0);
    checks++;
    if (obs() !== 8'b0000_0001) begin
      errors++;
      $display("FAIL hold_invalid: got %b expected %b", obs(), 8'b0000_0001);
    end
    // Inputs changing mid-cycle must not reach the outputs before the edge.
    drive(1'b1, 4'b0010, 4'b0010, 1'b0);
    @(negedge clk);
    bus.A = 4'b1111;
    bus.B = 4'b1111;
    #2;
    checks++;
    if (obs() !== 8'b1000_0100) begin
      errors++;
      $display("FAIL no_comb_path: got %b expected %b", obs(), 8'b1000_0100);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== 8'b1100_1110) begin
      errors++;
      $display("FAIL after_change: got %b expected %b", obs(), 8'b1100_1110);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'b0001, 4'b0010, 1'b0);
    checks++;
    if (obs() !== 8'b1000_0011) begin
      errors++;
      $display("FAIL b2b_0: got %b expected %b", obs(), 8'b1000_0011);
    end
    drive(1'b1, 4'b1000, 4'b1000, 1'b0);
    checks++;
    if (obs() !== 8'b1111_0000) begin
      errors++;
      $display("FAIL b2b_1: got %b expected %b", obs(), 8'b1111_0000);
    end
    drive(1'b1, 4'b0110, 4'b0011, 1'b1);
    checks++;
    if (obs() !== 8'b1010_1010) begin
      errors++;
      $display("FAIL b2b_2: got %b expected %b", obs(), 8'b1010_1010);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 4'b0011, 4'b0100, 1'b0);
    checks++;
    if (obs() !== 8'b1000_0111) begin
      errors++;
      $display("FAIL pre_reset_capture: got %b expected %b", obs(), 8'b1000_0111);
    end
    @(negedge clk);
    #2;
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    #1;
    checks++;
    if (obs() !== 8'b0000_0000) begin
      errors++;
      $display("FAIL async_reset_immediate: got %b expected %b", obs(), 8'b0000_0000);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== 8'b0000_0000) begin
      errors++;
      $display("FAIL reset_discard: got %b expected %b", obs(), 8'b0000_0000);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    bus.A   = 4'b0010;
    bus.B   = 4'b0011;
    bus.Cin = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sync_release_edge1: got out_valid=%b expected 0", bus.out_valid);
    end
    // Bounded wait for the synchronizer to let the first capture through.
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid === 1'b1) break;
      @(posedge clk);
      #1;
    end
    checks++;
    if (obs() !== 8'b1000_0110) begin
      errors++;
      $display("FAIL resume_after_reset: got %b expected %b", obs(), 8'b1000_0110);
    end
  endtask

  task automatic test_sweep();
    logic [4:0] exp_sum;
    logic [3:0] ea;
    logic [3:0] eb;
    logic       eovf;
    logic [7:0] exp_vec;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          ea      = 4'(a);
          eb      = 4'(b);
          exp_sum = 5'(a + b + c);
          eovf    = (ea[3] == eb[3]) && (exp_sum[3] != ea[3]);
          exp_vec = {1'b1, exp_sum[4], eovf, (exp_sum[3:0] == 4'b0000), exp_sum[3:0]};
          drive(1'b1, ea, eb, 1'(c));
          checks++;
          if (obs() !== exp_vec) begin
            errors++;
            $display("FAIL sweep a=%0d b=%0d c=%0d: got %b expected %b", a, b, c, obs(), exp_vec);
          end
        end
      end
    end
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_carry();
    test_overflow_zero();
    test_hold();
    test_back_to_back();
    test_async_reset();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
